ssp_slave_if: RTL and testbench

- SPI-mode-0 slave front end that converts external serial frames into the parallel SSP bus consumed by SSP_UART: SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI.
- Returns SSP_DO serially on MISO.
- Entirely in the Clk domain: external SCK, nSSEL and MOSI are oversampled through synchronizers. Clk must be at least 8x the SCK frequency.
- Sits directly upstream of SSP_UART in the I/O subsystem.

---
 rtl/ssp_slave_if.sv | 206 ++++++++++++++++++++
 tb/tb_ssp_slave_if.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_slave_if.sv
// SPI mode-0 slave front end: oversamples SCK/nSSEL/MOSI in the Clk domain and
// presents each frame as a parallel SSP bus transaction, returning SSP_DO on MISO.
module ssp_slave_if #(
    parameter int unsigned pSyncStages = 2,
    parameter int unsigned pDW         = 12
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           nSSEL,
    input  logic           SCK,
    input  logic           MOSI,
    output logic           MISO,
    output logic           MISO_OE,
    output logic           SSP_SSEL,
    output logic [2:0]     SSP_RA,
    output logic           SSP_WnR,
    output logic           SSP_En,
    output logic           SSP_EOC,
    output logic [pDW-1:0] SSP_DI,
    input  logic [pDW-1:0] SSP_DO,
    output logic           FrmErr
);

    localparam int unsigned SS = pSyncStages;
    localparam int unsigned CW = $clog2(pDW + 5);
    localparam int unsigned IW = (pDW > 1) ? $clog2(pDW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [SS-1:0]  sck_sync_q;
    logic [SS-1:0]  nssel_sync_q;
    logic [SS-1:0]  mosi_sync_q;
    logic           sck_hist_q;

    logic           sck_s;
    logic           mosi_s;
    logic           sel;
    logic           sck_rise;
    logic           sck_fall;
    logic [IW-1:0]  data_idx;

    state_t         state_q,  state_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [2:0]     hdr_q,    hdr_d;
    logic [pDW-1:0] rx_q,     rx_d;
    logic [pDW-1:0] tx_q,     tx_d;
    logic [2:0]     ra_q,     ra_d;
    logic           wnr_q,    wnr_d;
    logic [pDW-1:0] di_q,     di_d;
    logic           miso_q,   miso_d;
    logic           en_q,     en_d;
    logic           eoc_q,    eoc_d;
    logic           err_q,    err_d;
    logic           ssel_q;

    // Input synchronizers, preset to the idle bus (deselected, SCK low).
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sck_sync_q   <= '0;
            nssel_sync_q <= '1;
            mosi_sync_q  <= '0;
            sck_hist_q   <= 1'b0;
        end else begin
            sck_sync_q   <= {sck_sync_q[SS-2:0], SCK};
            nssel_sync_q <= {nssel_sync_q[SS-2:0], nSSEL};
            mosi_sync_q  <= {mosi_sync_q[SS-2:0], MOSI};
            sck_hist_q   <= sck_sync_q[SS-1];
        end
    end

    assign sck_s    = sck_sync_q[SS-1];
    assign mosi_s   = mosi_sync_q[SS-1];
    assign sel      = ~nssel_sync_q[SS-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;

    // Data bits arrive MSB first; cnt 4 maps to bit pDW-1, cnt pDW+3 to bit 0.
    assign data_idx = IW'(CW'(pDW + 3) - cnt_q);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            ra_q    <= '0;
            wnr_q   <= 1'b0;
            di_q    <= '0;
            miso_q  <= 1'b0;
            en_q    <= 1'b0;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
            ssel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            ra_q    <= ra_d;
            wnr_q   <= wnr_d;
            di_q    <= di_d;
            miso_q  <= miso_d;
            en_q    <= en_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
            ssel_q  <= sel;
        end
    end

    // Frame sequencer; a deselect always takes priority over a coincident SCK edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        ra_d    = ra_q;
        wnr_d   = wnr_q;
        di_d    = di_q;
        miso_d  = miso_q;
        en_d    = 1'b0;
        eoc_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                hdr_d  = '0;
                rx_d   = '0;
                miso_d = 1'b0;
                if (sel) begin
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                miso_d = 1'b0;
                if (!sel) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (sck_rise) begin
                    hdr_d = {hdr_q[1:0], mosi_s};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(3)) begin
                        state_d = ST_DATA;
                        ra_d    = hdr_q;
                        wnr_d   = mosi_s;
                        en_d    = 1'b1;
                        tx_d    = SSP_DO;
                    end
                end
            end

            ST_DATA: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_d[data_idx] = mosi_s;
                    cnt_d          = cnt_q + CW'(1);
                    if (cnt_q == CW'(pDW + 3)) begin
                        state_d = ST_DONE;
                        di_d    = rx_d;
                        eoc_d   = 1'b1;
                        miso_d  = 1'b0;
                    end
                end else if (sck_fall) begin
                    miso_d = tx_q[pDW-1];
                    tx_d   = {tx_q[pDW-2:0], 1'b0};
                end
            end

            ST_DONE: begin
                miso_d = 1'b0;
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign MISO     = miso_q;
    assign MISO_OE  = ssel_q;
    assign SSP_SSEL = ssel_q;
    assign SSP_RA   = ra_q;
    assign SSP_WnR  = wnr_q;
    assign SSP_En   = en_q;
    assign SSP_EOC  = eoc_q;
    assign SSP_DI   = di_q;
    assign FrmErr   = err_q;

endmodule

// File: tb/tb_ssp_slave_if.sv
// Bench for ssp_slave_if: drives SPI mode-0 frames at SCK = Clk/16 and checks
// pulse counts, held bus fields and MISO bits against a frame-level model.
module tb_ssp_slave_if;

    localparam int unsigned DW = 12;
    localparam int unsigned FL = DW + 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          nSSEL;
    logic          SCK;
    logic          MOSI;
    logic          MISO;
    logic          MISO_OE;
    logic          SSP_SSEL;
    logic [2:0]    SSP_RA;
    logic          SSP_WnR;
    logic          SSP_En;
    logic          SSP_EOC;
    logic [DW-1:0] SSP_DI;
    logic [DW-1:0] SSP_DO;
    logic          FrmErr;

    ssp_slave_if #(.pSyncStages(2), .pDW(DW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .nSSEL    (nSSEL),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .SSP_SSEL (SSP_SSEL),
        .SSP_RA   (SSP_RA),
        .SSP_WnR  (SSP_WnR),
        .SSP_En   (SSP_En),
        .SSP_EOC  (SSP_EOC),
        .SSP_DI   (SSP_DI),
        .SSP_DO   (SSP_DO),
        .FrmErr   (FrmErr)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    // Running pulse totals; frames take differences so only this block writes them.
    int tot_en   = 0;
    int tot_eoc  = 0;
    int tot_err  = 0;
    int tot_both = 0;

    always @(negedge Clk) begin
        if (SSP_En)            tot_en   = tot_en + 1;
        if (SSP_EOC)           tot_eoc  = tot_eoc + 1;
        if (FrmErr)            tot_err  = tot_err + 1;
        if (SSP_En && SSP_EOC) tot_both = tot_both + 1;
    end

    logic [2:0]    model_ra;
    logic          model_wnr;
    logic [DW-1:0] model_di;
    logic [DW-1:0] miso_bits;
    int            f_en, f_eoc, f_err, f_both;

    typedef struct {
        logic [2:0]    ra;
        logic          wnr;
        logic [DW-1:0] d;
        logic [DW-1:0] dov;
        int            n;
        int            en;
        int            eoc;
        int            err;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctrl_outs();
        return 32'({MISO, MISO_OE, SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, FrmErr});
    endfunction

    // Master side: MOSI changes while SCK low, MISO sampled just before each rise.
    task automatic run_frame(input logic [2:0] ra, input logic wnr, input logic [DW-1:0] d,
                             input logic [DW-1:0] dov, input int n, input int gap,
                             input int rst_at);
        logic [FL-1:0] bits;
        int            en0, eoc0, err0, both0;
        bit            aborted;
        bits      = {ra, wnr, d};
        SSP_DO    = dov;
        en0       = tot_en;
        eoc0      = tot_eoc;
        err0      = tot_err;
        both0     = tot_both;
        miso_bits = '0;
        aborted   = 1'b0;
        @(negedge Clk);
        nSSEL = 1'b0;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < n && !aborted; i++) begin
            MOSI = (i < int'(FL)) ? bits[FL-1-i] : 1'($urandom);
            repeat (8) @(negedge Clk);
            if (i >= 4 && i < int'(FL)) miso_bits[FL-1-i] = MISO;
            SCK = 1'b1;
            if (i + 1 == rst_at) begin
                Rst = 1'b1;
                @(negedge Clk);
                check("rst_ctrl_outs", ctrl_outs(), 32'd0);
                check("rst_di", 32'(SSP_DI), 32'd0);
                SCK   = 1'b0;
                nSSEL = 1'b1;
                repeat (6) @(negedge Clk);
                Rst = 1'b0;
                repeat (6) @(negedge Clk);
                check("rst_no_eoc", 32'(tot_eoc - eoc0), 32'd0);
                check("rst_no_frmerr", 32'(tot_err - err0), 32'd0);
                check("rst_idle_outs", ctrl_outs(), 32'd0);
                model_ra  = '0;
                model_wnr = 1'b0;
                model_di  = '0;
                aborted   = 1'b1;
            end else begin
                repeat (8) @(negedge Clk);
                SCK = 1'b0;
            end
        end
        if (!aborted) begin
            repeat (8) @(negedge Clk);
            nSSEL = 1'b1;
            repeat (gap) @(negedge Clk);
        end
        f_en   = tot_en - en0;
        f_eoc  = tot_eoc - eoc0;
        f_err  = tot_err - err0;
        f_both = tot_both - both0;
    endtask

    // Frame-level rules: En once the header is in, EOC once all FL bits are in,
    // FrmErr once for any short frame or once per surplus rise.
    task automatic check_frame(input string tag, input logic [2:0] ra, input logic wnr,
                               input logic [DW-1:0] d, input logic [DW-1:0] dov, input int n,
                               input int exp_en, input int exp_eoc, input int exp_err);
        if (n >= 4) begin
            model_ra  = ra;
            model_wnr = wnr;
        end
        if (n >= int'(FL)) model_di = d;
        check({tag, "_en_cnt"},  32'(f_en),  32'(exp_en));
        check({tag, "_eoc_cnt"}, 32'(f_eoc), 32'(exp_eoc));
        check({tag, "_err_cnt"}, 32'(f_err), 32'(exp_err));
        check({tag, "_en_eoc_overlap"}, 32'(f_both), 32'd0);
        check({tag, "_ra"},  32'(SSP_RA),  32'(model_ra));
        check({tag, "_wnr"}, 32'(SSP_WnR), 32'(model_wnr));
        check({tag, "_di"},  32'(SSP_DI),  32'(model_di));
        if (n >= int'(FL)) check({tag, "_miso_bits"}, 32'(miso_bits), 32'(dov));
        check({tag, "_idle_pins"}, 32'({MISO, MISO_OE, SSP_SSEL}), 32'd0);
    endtask

    function automatic int model_err(input int n);
        return (n >= int'(FL)) ? n - int'(FL) : 1;
    endfunction

    initial begin
        tbl[0] = '{ra: 3'd0, wnr: 1'b1, d: 12'h2A5, dov: 12'h000, n: 16, en: 1, eoc: 1, err: 0};
        tbl[1] = '{ra: 3'd2, wnr: 1'b0, d: 12'h000, dov: 12'hC3A, n: 16, en: 1, eoc: 1, err: 0};
        tbl[2] = '{ra: 3'd5, wnr: 1'b1, d: 12'h7FF, dov: 12'h000, n: 9,  en: 1, eoc: 0, err: 1};
        tbl[3] = '{ra: 3'd3, wnr: 1'b1, d: 12'h5A5, dov: 12'h123, n: 16, en: 1, eoc: 1, err: 0};
        tbl[4] = '{ra: 3'd7, wnr: 1'b0, d: 12'hABC, dov: 12'h456, n: 18, en: 1, eoc: 1, err: 2};
        tbl[5] = '{ra: 3'd1, wnr: 1'b1, d: 12'hFFF, dov: 12'h0F0, n: 2,  en: 0, eoc: 0, err: 1};
        tbl[6] = '{ra: 3'd6, wnr: 1'b0, d: 12'h801, dov: 12'hFFF, n: 0,  en: 0, eoc: 0, err: 1};

        Rst       = 1'b1;
        nSSEL     = 1'b1;
        SCK       = 1'b0;
        MOSI      = 1'b0;
        SSP_DO    = '0;
        model_ra  = '0;
        model_wnr = 1'b0;
        model_di  = '0;
        repeat (4) @(negedge Clk);
        check("reset_ctrl_outs", ctrl_outs(), 32'd0);
        check("reset_di", 32'(SSP_DI), 32'd0);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);

        // SSP_SSEL must follow the pin after exactly pSyncStages+1 edges.
        @(posedge Clk);
        #1 nSSEL = 1'b0;
        repeat (2) @(posedge Clk);
        #1 check("ssel_latency_early", 32'(SSP_SSEL), 32'd0);
        @(posedge Clk);
        #1 check("ssel_latency_on", 32'({SSP_SSEL, MISO_OE}), 32'd3);
        nSSEL = 1'b1;
        repeat (8) @(negedge Clk);

        for (int k = 0; k < 7; k++) begin
            run_frame(tbl[k].ra, tbl[k].wnr, tbl[k].d, tbl[k].dov, tbl[k].n, 6, 0);
            check_frame($sformatf("tbl%0d", k), tbl[k].ra, tbl[k].wnr, tbl[k].d, tbl[k].dov,
                        tbl[k].n, tbl[k].en, tbl[k].eoc, tbl[k].err);
        end

        // Back-to-back frames separated by 4 Clk of deselect.
        run_frame(3'd4, 1'b1, 12'h3C5, 12'h9A6, 16, 4, 0);
        check_frame("b2b_a", 3'd4, 1'b1, 12'h3C5, 12'h9A6, 16, 1, 1, 0);
        run_frame(3'd1, 1'b0, 12'hE17, 12'h5D2, 16, 4, 0);
        check_frame("b2b_b", 3'd1, 1'b0, 12'hE17, 12'h5D2, 16, 1, 1, 0);

        // Reset at rise 10, then a clean frame.
        run_frame(3'd5, 1'b1, 12'h0F3, 12'h111, 16, 6, 10);
        run_frame(3'd6, 1'b1, 12'hB4D, 12'h7E1, 16, 6, 0);
        check_frame("post_rst", 3'd6, 1'b1, 12'hB4D, 12'h7E1, 16, 1, 1, 0);

        for (int r = 0; r < 20; r++) begin
            logic [2:0]    ra;
            logic          wnr;
            logic [DW-1:0] d, dov;
            int            n;
            ra  = 3'($urandom);
            wnr = 1'($urandom);
            d   = DW'($urandom);
            dov = DW'($urandom);
            n   = (r % 3 == 0) ? int'($urandom_range(0, 18)) : int'(FL);
            run_frame(ra, wnr, d, dov, n, 6, 0);
            check_frame($sformatf("rnd%0d", r), ra, wnr, d, dov, n,
                        (n >= 4) ? 1 : 0, (n >= int'(FL)) ? 1 : 0, model_err(n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
